// File: rtl/ibuf_pkg.sv
// Shared defaults and helpers for the input-buffer synchroniser/debounce block.
package ibuf_pkg;

   localparam int IBUF_SYNC_STAGES_DEF = 2;
   localparam int IBUF_DEBOUNCE_DEF    = 16;

   // Counter must hold DEBOUNCE_CYCLES-1; one spare bit keeps cycles=1 legal.
   function automatic int ibuf_cnt_w(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/ibuf_chan.sv
// One input channel: polarity, synchroniser, debounce filter, edge pulses.
// Debounce counter present only when IBUF_DEBOUNCE_EN is defined.
module ibuf_chan #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic pad_i,
   input  logic en_i,
   input  logic invert_i,
   output logic data_o,
   output logic rise_o,
   output logic fall_o
);
   import ibuf_pkg::*;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   stable_q;
   logic                   stable_d;
   logic                   rise_d;
   logic                   fall_d;

   // Inversion ahead of the chain, so toggling invert_i looks like a pad change.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) sync_q <= {SYNC_STAGES{RESET_VAL}};
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i ^ invert_i};
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef IBUF_DEBOUNCE_EN
   localparam int            CW = ibuf_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (!en_i) begin
         stable_d = RESET_VAL;
      end else if (s != stable_q) begin
         if (cnt_q >= TC) stable_d = s;
         else             cnt_d    = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`else
   logic unused_dbc;
   assign unused_dbc = (DEBOUNCE_CYCLES > 0);

   always_comb begin
      stable_d = en_i ? s : RESET_VAL;
   end
`endif

   // Forcing to RESET_VAL on disable must not look like an edge.
   always_comb begin
      rise_d = en_i &  stable_d & ~stable_q;
      fall_d = en_i & ~stable_d &  stable_q;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         stable_q <= RESET_VAL;
         rise_o   <= 1'b0;
         fall_o   <= 1'b0;
      end else begin
         stable_q <= stable_d;
         rise_o   <= rise_d;
         fall_o   <= fall_d;
      end
   end

   assign data_o = stable_q;

endmodule

// File: rtl/ibuf_sync_filter.sv
// Multi-channel input conditioning: NUM_CH independent ibuf_chan instances.
// Debounce filtering is built in when IBUF_DEBOUNCE_EN is defined.
module ibuf_sync_filter
   import ibuf_pkg::*;
#(
   parameter int                NUM_CH          = 8,
   parameter int                SYNC_STAGES     = IBUF_SYNC_STAGES_DEF,
   parameter int                DEBOUNCE_CYCLES = IBUF_DEBOUNCE_DEF,
   parameter logic [NUM_CH-1:0] RESET_VAL       = {NUM_CH{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [NUM_CH-1:0] pad_i,
   input  logic [NUM_CH-1:0] en_i,
   input  logic [NUM_CH-1:0] invert_i,
   output logic [NUM_CH-1:0] data_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   output logic              change_o
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      ibuf_chan #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_VAL[i])
      ) u_chan (
         .clk_i    (clk_i),
         .rstn_i   (rstn_i),
         .pad_i    (pad_i[i]),
         .en_i     (en_i[i]),
         .invert_i (invert_i[i]),
         .data_o   (data_o[i]),
         .rise_o   (rise_o[i]),
         .fall_o   (fall_o[i])
      );
   end

   assign change_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_ibuf_sync_filter.sv
// Directed bench for ibuf_sync_filter (default parameters, either IBUF_DEBOUNCE_EN build).
module tb_ibuf_sync_filter;

`ifdef IBUF_DEBOUNCE_EN
   localparam int LAT    = 18;
   localparam int RE_LAT = 16;
`else
   localparam int LAT    = 3;
   localparam int RE_LAT = 1;
`endif

   logic       clk_i = 1'b0;
   logic       rstn_i = 1'b1;
   logic [7:0] pad_i = 8'h00;
   logic [7:0] en_i = 8'h00;
   logic [7:0] invert_i = 8'h00;
   logic [7:0] data_o;
   logic [7:0] rise_o;
   logic [7:0] fall_o;
   logic       change_o;

   int total = 0;
   int bad   = 0;

   ibuf_sync_filter dut (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .pad_i    (pad_i),
      .en_i     (en_i),
      .invert_i (invert_i),
      .data_o   (data_o),
      .rise_o   (rise_o),
      .fall_o   (fall_o),
      .change_o (change_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int rise_t;
      int fall_t;
      int n_rise;
      int n_fall;
      logic acc;

      // Reset with all pads high: nothing may leak through
      pad_i = 8'hFF;
      en_i  = 8'hFF;
      #2 rstn_i = 1'b0;
      step(3);
      chk("rst_data", {24'h0, data_o}, 32'h00);
      chk("rst_pulse", {16'h0, rise_o, fall_o}, 32'h0);
      chk("rst_change", {31'h0, change_o}, 32'h0);
      rstn_i = 1'b1;
      acc = 1'b0;
      for (int t = 1; t < LAT; t++) begin
         step(1);
         acc = acc | (|data_o) | (|rise_o) | change_o;
      end
      chk("post_rst_quiet", {31'h0, acc}, 32'h0);
      step(1);
      chk("rst_accept_data", {24'h0, data_o}, 32'hFF);
      chk("rst_accept_rise", {24'h0, rise_o}, 32'hFF);
      chk("rst_accept_change", {31'h0, change_o}, 32'h1);
      step(1);
      chk("rise_one_cycle", {24'h0, rise_o}, 32'h00);

      pad_i = 8'h00;
      step(LAT - 1);
      chk("fall_pre_data", {24'h0, data_o}, 32'hFF);
      step(1);
      chk("fall_all", {24'h0, fall_o}, 32'hFF);
      chk("fall_data", {24'h0, data_o}, 32'h00);
      step(3);

      // Clean step on channel 0
      pad_i[0] = 1'b1;
      step(LAT - 1);
      chk("step0_pre", {24'h0, data_o}, 32'h00);
      step(1);
      chk("step0_data", {24'h0, data_o}, 32'h01);
      chk("step0_rise", {24'h0, rise_o}, 32'h01);
      chk("step0_change", {31'h0, change_o}, 32'h1);
      step(1);
      chk("step0_change_off", {31'h0, change_o}, 32'h0);
      pad_i[0] = 1'b0;
      step(LAT + 2);

`ifdef IBUF_DEBOUNCE_EN
      // 15-cycle glitch on channel 3 is rejected
      pad_i[3] = 1'b1;
      step(15);
      pad_i[3] = 1'b0;
      acc = 1'b0;
      for (int t = 0; t < 40; t++) begin
         acc = acc | data_o[3] | rise_o[3] | fall_o[3];
         step(1);
      end
      chk("glitch15", {31'h0, acc}, 32'h0);

      // 16-cycle pulse passes: rise at 18, fall 16 later
      rise_t = -1; fall_t = -1;
      pad_i[3] = 1'b1;
      for (int t = 1; t <= 60; t++) begin
         step(1);
         if (t == 16) pad_i[3] = 1'b0;
         if (rise_o[3]) rise_t = t;
         if (fall_o[3]) fall_t = t;
      end
      chk("pulse16_rise_t", rise_t, 18);
      chk("pulse16_fall_t", fall_t, 34);

      // Bounce on channel 1: 1,0,1 at 5-cycle intervals, then hold 1
      rise_t = -1; n_rise = 0; n_fall = 0;
      pad_i[1] = 1'b1;
      for (int t = 1; t <= 50; t++) begin
         step(1);
         if (t == 5)  pad_i[1] = 1'b0;
         if (t == 10) pad_i[1] = 1'b1;
         if (rise_o[1]) begin rise_t = t; n_rise++; end
         if (fall_o[1]) n_fall++;
      end
      chk("bounce_rise_t", rise_t, 28);
      chk("bounce_n_rise", n_rise, 1);
      chk("bounce_n_fall", n_fall, 0);
      pad_i[1] = 1'b0;
      step(LAT + 2);
`else
      // Single-cycle pulse on channel 5 follows after 3 edges
      rise_t = -1; fall_t = -1;
      pad_i[5] = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         step(1);
         if (t == 1) pad_i[5] = 1'b0;
         if (rise_o[5]) rise_t = t;
         if (fall_o[5]) fall_t = t;
      end
      chk("pulse1_rise_t", rise_t, 3);
      chk("pulse1_fall_t", fall_t, 4);
`endif

      // Disable forces channel 2 low without a fall pulse
      pad_i[2] = 1'b1;
      step(LAT + 1);
      chk("dis_pre_data", {31'h0, data_o[2]}, 32'h1);
      en_i[2] = 1'b0;
      step(1);
      chk("dis_data", {31'h0, data_o[2]}, 32'h0);
      chk("dis_nofall", {24'h0, fall_o}, 32'h00);
      chk("dis_nochange", {31'h0, change_o}, 32'h0);
      invert_i[2] = 1'b1;
      pad_i[2]    = 1'b0;
      step(4);
      chk("dis_held", {31'h0, data_o[2]}, 32'h0);
      en_i[2] = 1'b1;
      rise_t = -1;
      for (int t = 1; t <= 25; t++) begin
         step(1);
         if (rise_o[2]) rise_t = t;
      end
      chk("reen_rise_t", rise_t, RE_LAT);
      chk("reen_data", {31'h0, data_o[2]}, 32'h1);
      invert_i[2] = 1'b0;
      step(LAT + 3);
      chk("inv_off_data", {24'h0, data_o}, 32'h00);

      // Simultaneous edges on channels 7:4
      pad_i = 8'hF0;
      step(LAT);
      chk("multi_rise", {24'h0, rise_o}, 32'hF0);
      chk("multi_change", {31'h0, change_o}, 32'h1);

      // Reset mid-count on falling channels: counting restarts after release
      pad_i = 8'h00;
      step(LAT - 3);
      rstn_i = 1'b0;
      #1;
      chk("midrst_data", {24'h0, data_o}, 32'h00);
      step(1);
      rstn_i = 1'b1;
      pad_i  = 8'h02;
      step(LAT - 1);
      chk("midrst_pre", {24'h0, data_o}, 32'h00);
      step(1);
      chk("midrst_rise", {24'h0, rise_o}, 32'h02);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ibuf_sync_filter.md
Name: ibuf_sync_filter

Overview:
- Multi-channel input conditioning block that follows the board-level input buffers.
- Per channel it provides optional polarity inversion, a metastability synchroniser, a debounce filter, and single-cycle rise/fall edge pulses.
- Feeds GPIO, button and switch inputs on the Arty A7 CHERIoT platform into clock-domain-safe, glitch-free logic.

Parameters:
- NUM_CH, 8, number of independent input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (2..4).
- DEBOUNCE_CYCLES, 16, consecutive cycles a new level must persist before acceptance (1..65535).
- RESET_VAL, {NUM_CH{1'b0}}, per-channel reset/disabled value of the filtered level.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  asynchronous active-low reset.
- pad_i  input  NUM_CH  raw asynchronous pad levels.
- en_i  input  NUM_CH  per-channel enable (synchronous to clk_i).
- invert_i  input  NUM_CH  per-channel polarity inversion (synchronous to clk_i).
- data_o  output  NUM_CH  filtered, synchronised level.
- rise_o  output  NUM_CH  one-cycle pulse when data_o goes 0->1.
- fall_o  output  NUM_CH  one-cycle pulse when data_o goes 1->0.
- change_o  output  1  OR of all rise_o and fall_o bits.

Behaviour:
- Clock and reset: one clock (clk_i). Reset is asynchronous and active-low (rstn_i).
- Reset values: all sync flops = RESET_VAL; data_o = RESET_VAL; all counters = 0; rise_o/fall_o/change_o = 0.
- Input path per channel: x = pad_i ^ invert_i, fed into a SYNC_STAGES flop chain; s = last stage.
- Filter state per channel: stable level (drives data_o) and counter cnt, width clog2(DEBOUNCE_CYCLES)+1.
- Each cycle while enabled:
  - s == stable: cnt <= 0.
  - s != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s and cnt <= 0.
- Latency: a clean pad step before edge 0 appears on data_o after edge SYNC_STAGES+DEBOUNCE_CYCLES (default: edge 18).
- Glitch rejection: any bounce back to stable before the counter terminates restarts the count from 0. Pulses of DEBOUNCE_CYCLES-1 cycles or fewer never reach data_o.
- Edge pulses: rise_o/fall_o are registered and high for exactly the first cycle data_o shows the new value; change_o is in the same cycle.
- Inversion: invert_i is applied before the synchroniser. Toggling invert_i is treated as an input change, so it is debounced and produces an edge pulse.
- Disable (en_i = 0):
  - stable forced to RESET_VAL, cnt held at 0, no pulses.
  - The forcing itself generates no rise_o/fall_o.
  - The sync chain keeps running.
- Re-enable: stable starts from RESET_VAL and normal filtering resumes. A differing input is accepted after DEBOUNCE_CYCLES cycles.
- Reset asserted mid-count: everything returns immediately to reset values. Counting restarts from 0 after release.
- Channel independence: channels are fully independent; simultaneous edges on several channels each pulse in the same cycle.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Optional Feature:
- Macro: IBUF_DEBOUNCE_EN.
- Defined: debounce filter as described above.
- Undefined:
  - Counters removed; stable <= s every cycle while enabled.
  - Latency SYNC_STAGES+1 edges.
  - No glitch rejection beyond synchronisation.
  - DEBOUNCE_CYCLES ignored.
  - Edge, enable and reset rules unchanged.

Decomposition:
- Package ibuf_pkg:
  - default constants IBUF_SYNC_STAGES_DEF=2 and IBUF_DEBOUNCE_DEF=16;
  - counter-width function ibuf_cnt_w(cycles).
- Sub-module ibuf_chan:
  - one channel's inversion, sync chain, filter and edge pulse generation;
  - instantiated NUM_CH times via generate;
  - change_o reduction stays in the top level.

Test Plan:
- Reset: hold rstn_i=0 with pad_i=8'hFF, RESET_VAL=0 -> data_o=8'h00, all pulses 0; they stay 0 for 17 cycles after release.
- Clean step: pad_i[0] 0->1 before edge 0, en_i=8'hFF -> data_o[0]=1 and rise_o[0]=1 for one cycle at edge 18; change_o=1 the same cycle.
- Glitch: pad_i[3] high for 15 cycles then low -> data_o[3] stays 0, no pulses. High for 16 cycles -> rise_o[3] then fall_o[3] 16 cycles apart.
- Bounce: pad_i[1] toggles 1,0,1 at 5-cycle intervals then holds 1 -> single rise_o[1], 18 cycles after the final 0->1 transition.
- Disable/invert: with data_o[2]=1, drop en_i[2] -> data_o[2]=0 next cycle, no fall_o[2]. Re-enable with invert_i[2]=1 and pad_i[2]=0 -> rise_o[2] after 16 cycles.
- Macro off: build without IBUF_DEBOUNCE_EN; a 1-cycle pad pulse wide enough to be captured -> data_o follows after 3 edges, with rise_o then fall_o.
